// File: rtl/p405s_srm_msk_encode.sv
// rtl/p405s_srm_msk_encode.sv - iterative MB/ME recovery from a 32-bit rotate mask
// Scans 4 bits per cycle over 8 cycles, counting rise/fall edges with wrap-around neighbours.
module p405s_srm_msk_encode (
    input  logic        CB,
    input  logic        resetL,
    input  logic        startReq,
    input  logic        abortReq,
    input  logic [0:31] maskIn,
    output logic        busy,
    output logic        doneVld,
    output logic [0:4]  mbField,
    output logic [0:4]  meField,
    output logic        maskValid,
    output logic        maskAllOnes,
    output logic        maskZero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [0:31] mask_reg;
    logic [2:0]  chunk_cnt;
    logic [1:0]  rise_cnt;
    logic [1:0]  fall_cnt;
    logic [4:0]  mb_acc;
    logic [4:0]  me_acc;
    logic        all_ones_r;
    logic        all_zero_r;

    logic        start_acc;
    logic        scan_last;
    logic [2:0]  chunk_rise;
    logic [2:0]  chunk_fall;
    logic [4:0]  chunk_mb;
    logic [4:0]  chunk_me;
    logic [4:0]  pos;
    logic [4:0]  prv;
    logic [4:0]  nxt;
    logic [2:0]  rise_sum;
    logic [2:0]  fall_sum;
    logic [1:0]  rise_nxt;
    logic [1:0]  fall_nxt;

    assign start_acc = (state == IDLE) && startReq && !abortReq;
    assign scan_last = (state == SCAN) && (chunk_cnt == 3'd7) && !abortReq;

    always_ff @(posedge CB or negedge resetL) begin
        if (!resetL) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (startReq) state_nxt = SCAN;
            SCAN:    if (chunk_cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abortReq) begin
            state_nxt = IDLE;
        end
    end

    // Edge detection for the current chunk; 5-bit index arithmetic gives the mod-32 wrap.
    always_comb begin
        chunk_rise = 3'd0;
        chunk_fall = 3'd0;
        chunk_mb   = mb_acc;
        chunk_me   = me_acc;
        pos        = 5'd0;
        prv        = 5'd0;
        nxt        = 5'd0;
        for (int j = 0; j < 4; j++) begin
            pos = {chunk_cnt, 2'b00} + 5'(j);
            prv = pos - 5'd1;
            nxt = pos + 5'd1;
            if (mask_reg[pos] && !mask_reg[prv]) begin
                chunk_rise = chunk_rise + 3'd1;
                chunk_mb   = pos;
            end
            if (mask_reg[pos] && !mask_reg[nxt]) begin
                chunk_fall = chunk_fall + 3'd1;
                chunk_me   = pos;
            end
        end
    end

    always_comb begin
        rise_sum = {1'b0, rise_cnt} + chunk_rise;
        fall_sum = {1'b0, fall_cnt} + chunk_fall;
        rise_nxt = (rise_sum >= 3'd2) ? 2'd2 : rise_sum[1:0];
        fall_nxt = (fall_sum >= 3'd2) ? 2'd2 : fall_sum[1:0];
    end

    always_ff @(posedge CB or negedge resetL) begin
        if (!resetL) begin
            mask_reg    <= '0;
            chunk_cnt   <= 3'd0;
            rise_cnt    <= 2'd0;
            fall_cnt    <= 2'd0;
            mb_acc      <= 5'd0;
            me_acc      <= 5'd0;
            all_ones_r  <= 1'b0;
            all_zero_r  <= 1'b0;
            busy        <= 1'b0;
            doneVld     <= 1'b0;
            mbField     <= 5'd0;
            meField     <= 5'd0;
            maskValid   <= 1'b0;
            maskAllOnes <= 1'b0;
            maskZero    <= 1'b0;
        end else begin
            busy    <= (state_nxt != IDLE);
            doneVld <= 1'b0;
            if (abortReq) begin
                mbField     <= 5'd0;
                meField     <= 5'd0;
                maskValid   <= 1'b0;
                maskAllOnes <= 1'b0;
                maskZero    <= 1'b0;
            end else if (start_acc) begin
                mask_reg    <= maskIn;
                chunk_cnt   <= 3'd0;
                rise_cnt    <= 2'd0;
                fall_cnt    <= 2'd0;
                mb_acc      <= 5'd0;
                me_acc      <= 5'd0;
                mbField     <= 5'd0;
                meField     <= 5'd0;
                maskValid   <= 1'b0;
                maskAllOnes <= 1'b0;
                maskZero    <= 1'b0;
            end else if (state == SCAN) begin
                chunk_cnt <= chunk_cnt + 3'd1;
                rise_cnt  <= rise_nxt;
                fall_cnt  <= fall_nxt;
                mb_acc    <= chunk_mb;
                me_acc    <= chunk_me;
                if (chunk_cnt == 3'd0) begin
                    all_ones_r <= &mask_reg;
                    all_zero_r <= ~|mask_reg;
                end
                // Last chunk folds its own edges in via the *_nxt values.
                if (scan_last) begin
                    doneVld <= 1'b1;
                    if (all_ones_r) begin
                        maskValid   <= 1'b1;
                        maskAllOnes <= 1'b1;
                        mbField     <= 5'd0;
                        meField     <= 5'd31;
                    end else if (all_zero_r) begin
                        maskZero    <= 1'b1;
                        maskValid   <= 1'b0;
                        mbField     <= 5'd0;
                        meField     <= 5'd0;
                    end else if (rise_nxt == 2'd1 && fall_nxt == 2'd1) begin
                        maskValid   <= 1'b1;
                        mbField     <= chunk_mb;
                        meField     <= chunk_me;
                    end else begin
                        maskValid   <= 1'b0;
                        mbField     <= 5'd0;
                        meField     <= 5'd0;
                    end
                end
            end
        end
    end

endmodule
